// File: rtl/disp_scan_mux.sv
// disp_scan_mux: scans four hex digits onto one MC14495-style decoder and a
// 4-digit common-anode display. New values are staged and only promoted to
// the displayed (shadow) copy at frame boundaries, so a frame never mixes
// old and new digits.
module disp_scan_mux #(
    parameter int SCAN_DIV = 100000,
    parameter int LZB_EN   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LEs,
    input  logic        load,
    output logic [3:0]  AN,
    output logic [3:0]  HEX,
    output logic        point,
    output logic        LE,
    output logic        frame
);

    // Prescaler width; a one-clock slot still needs a 1-bit register.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    // Leading-zero blank for digit k: digit 0 is never blanked; digit k>=1
    // blanks when it and every more significant nibble are zero.
    function automatic logic lzb_blank(input logic [1:0] k, input logic [15:0] h);
        logic b;
        b = 1'b0;
        case (k)
            2'd1:    b = (h[15:4]  == 12'h000);
            2'd2:    b = (h[15:8]  == 8'h00);
            2'd3:    b = (h[15:12] == 4'h0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    logic [15:0]   stage_hex_q;
    logic [3:0]    stage_pt_q;
    logic [3:0]    stage_le_q;
    logic          pend_q;

    logic [15:0]   shadow_hex_q;
    logic [3:0]    shadow_pt_q;
    logic [3:0]    shadow_le_q;

    logic [3:0]    an_q, an_d;
    logic [3:0]    hex_q, hex_d;
    logic          point_q, point_d;
    logic          le_q, le_d;
    logic          frame_q;

    logic          tick;
    logic          boundary;
    logic          lzb;

    // Slot timing: tick ends a digit slot, boundary ends the whole frame.
    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        boundary = tick && (idx_q == 2'd3);
        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
    end

    // Prescaler and digit index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Load handling: mid-frame loads go to the stage (last one wins) and are
    // promoted at the boundary; a load landing on the boundary goes straight
    // to the shadow and supersedes anything pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_hex_q  <= 16'h0000;
            stage_pt_q   <= 4'h0;
            stage_le_q   <= 4'h0;
            pend_q       <= 1'b0;
            shadow_hex_q <= 16'h0000;
            shadow_pt_q  <= 4'h0;
            shadow_le_q  <= 4'hF;
        end else begin
            if (load && boundary) begin
                shadow_hex_q <= hexs;
                shadow_pt_q  <= points;
                shadow_le_q  <= LEs;
                pend_q       <= 1'b0;
            end else if (load) begin
                stage_hex_q  <= hexs;
                stage_pt_q   <= points;
                stage_le_q   <= LEs;
                pend_q       <= 1'b1;
            end else if (boundary && pend_q) begin
                shadow_hex_q <= stage_hex_q;
                shadow_pt_q  <= stage_pt_q;
                shadow_le_q  <= stage_le_q;
                pend_q       <= 1'b0;
            end
        end
    end

    // Next output values for the digit currently selected by idx.
    always_comb begin
        lzb     = (LZB_EN != 0) ? lzb_blank(idx_q, shadow_hex_q) : 1'b0;
        an_d    = ~(4'b0001 << idx_q);
        hex_d   = shadow_hex_q[{idx_q, 2'b00} +: 4];
        point_d = shadow_pt_q[idx_q];
        le_d    = shadow_le_q[idx_q] | lzb;
    end

    // Registered outputs, one clock behind idx/shadow; reset keeps display dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q    <= 4'hF;
            hex_q   <= 4'h0;
            point_q <= 1'b0;
            le_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            hex_q   <= hex_d;
            point_q <= point_d;
            le_q    <= le_d;
            frame_q <= boundary;
        end
    end

    assign AN    = an_q;
    assign HEX   = hex_q;
    assign point = point_q;
    assign LE    = le_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux: main instance (SCAN_DIV=4), a
// leading-zero-blanking instance (SCAN_DIV=4, LZB_EN=1) and a one-clock-slot
// instance (SCAN_DIV=1), all sharing clock, reset and load inputs.
module tb_disp_scan_mux;

    logic        clk;
    logic        rst;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  LEs;
    logic        load;

    logic [3:0] an_m, hex_m, an_z, hex_z, an_f, hex_f;
    logic       pt_m, le_m, fr_m, pt_z, le_z, fr_z, pt_f, le_f, fr_f;

    int checks;
    int failures;
    int n;

    disp_scan_mux #(.SCAN_DIV(4), .LZB_EN(0)) u_main (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs), .load(load),
        .AN(an_m), .HEX(hex_m), .point(pt_m), .LE(le_m), .frame(fr_m));

    disp_scan_mux #(.SCAN_DIV(4), .LZB_EN(1)) u_lzb (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs), .load(load),
        .AN(an_z), .HEX(hex_z), .point(pt_z), .LE(le_z), .frame(fr_z));

    disp_scan_mux #(.SCAN_DIV(1), .LZB_EN(0)) u_fast (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs), .load(load),
        .AN(an_f), .HEX(hex_f), .point(pt_f), .LE(le_f), .frame(fr_f));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // One step of the SCAN_DIV=4 instances; the digit shown after edge n is
    // ((n-1)/4)%4 and frame pulses after every 16th edge.
    task automatic step_chk(input logic [15:0] hx, input logic [3:0] pt,
                            input logic [3:0] le, input logic [3:0] zle);
        int d;
        step();
        d = ((n - 1) / 4) % 4;
        chk("main_AN",    {12'h0, an_m},  {12'h0, ~(4'b0001 << d)});
        chk("main_HEX",   {12'h0, hex_m}, (hx >> (4 * d)) & 16'h000F);
        chk("main_point", {15'h0, pt_m},  {15'h0, pt[d]});
        chk("main_LE",    {15'h0, le_m},  {15'h0, le[d]});
        chk("main_frame", {15'h0, fr_m},  {15'h0, (n % 16) == 0});
        chk("lzb_HEX",    {12'h0, hex_z}, (hx >> (4 * d)) & 16'h000F);
        chk("lzb_LE",     {15'h0, le_z},  {15'h0, zle[d]});
    endtask

    task automatic check_n(input logic [15:0] hx, input logic [3:0] pt,
                           input logic [3:0] le, input logic [3:0] zle, input int cnt);
        for (int i = 0; i < cnt; i++) step_chk(hx, pt, le, zle);
    endtask

    // Post-reset idle: dark display, plus one-clock-slot instance stepping AN each clock.
    task automatic idle_chk(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            step_chk(16'h0000, 4'h0, 4'hF, 4'hF);
            chk("fast_AN",    {12'h0, an_f}, {12'h0, ~(4'b0001 << ((n - 1) % 4))});
            chk("fast_frame", {15'h0, fr_f}, {15'h0, (n % 4) == 0});
            chk("fast_LE",    {15'h0, le_f}, 16'h0001);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_AN_main",  {12'h0, an_m},  16'h000F);
        chk("rst_HEX_main", {12'h0, hex_m}, 16'h0000);
        chk("rst_pt_main",  {15'h0, pt_m},  16'h0000);
        chk("rst_LE_main",  {15'h0, le_m},  16'h0001);
        chk("rst_fr_main",  {15'h0, fr_m},  16'h0000);
        chk("rst_AN_lzb",   {12'h0, an_z},  16'h000F);
        chk("rst_LE_lzb",   {15'h0, le_z},  16'h0001);
        chk("rst_AN_fast",  {12'h0, an_f},  16'h000F);
        chk("rst_LE_fast",  {15'h0, le_f},  16'h0001);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n        = 0;
        rst      = 1'b1;
        load     = 1'b0;
        hexs     = 16'h0000;
        points   = 4'h0;
        LEs      = 4'h0;

        // Reset state, then release between edges.
        step();
        step();
        chk_reset_state();
        #2 rst = 1'b0;
        n = 0;

        // 1: free-running scan, no load.
        idle_chk(40);

        // 2: mid-frame load held back until the next frame.
        hexs   = 16'h1A2F;
        points = 4'b0100;
        LEs    = 4'h0;
        load   = 1'b1;
        step_chk(16'h0000, 4'h0, 4'hF, 4'hF);
        load   = 1'b0;
        check_n(16'h0000, 4'h0, 4'hF, 4'hF, 7);
        check_n(16'h1A2F, 4'b0100, 4'h0, 4'h0, 16);

        // 3: two loads in one frame, last one wins.
        check_n(16'h1A2F, 4'b0100, 4'h0, 4'h0, 2);
        hexs   = 16'h1111;
        points = 4'h0;
        load   = 1'b1;
        step_chk(16'h1A2F, 4'b0100, 4'h0, 4'h0);
        load   = 1'b0;
        check_n(16'h1A2F, 4'b0100, 4'h0, 4'h0, 2);
        hexs   = 16'h2222;
        load   = 1'b1;
        step_chk(16'h1A2F, 4'b0100, 4'h0, 4'h0);
        load   = 1'b0;
        check_n(16'h1A2F, 4'b0100, 4'h0, 4'h0, 10);
        check_n(16'h2222, 4'h0, 4'h0, 4'h0, 15);

        // 4: load exactly on the boundary edge.
        hexs   = 16'h0000;
        load   = 1'b1;
        step_chk(16'h2222, 4'h0, 4'h0, 4'h0);
        load   = 1'b0;
        check_n(16'h0000, 4'h0, 4'h0, 4'b1110, 15);

        // 5: leading-zero blanking.
        hexs   = 16'h0050;
        load   = 1'b1;
        step_chk(16'h0000, 4'h0, 4'h0, 4'b1110);
        load   = 1'b0;
        check_n(16'h0050, 4'h0, 4'h0, 4'b1100, 15);
        hexs   = 16'h0000;
        load   = 1'b1;
        step_chk(16'h0050, 4'h0, 4'h0, 4'b1100);
        load   = 1'b0;
        check_n(16'h0000, 4'h0, 4'h0, 4'b1110, 16);

        // 6: reset mid-frame with a pending load.
        hexs   = 16'hBEEF;
        points = 4'hF;
        LEs    = 4'h0;
        load   = 1'b1;
        step_chk(16'h0000, 4'h0, 4'h0, 4'b1110);
        load   = 1'b0;
        check_n(16'h0000, 4'h0, 4'h0, 4'b1110, 4);
        #2 rst = 1'b1;
        #1;
        chk_reset_state();
        step();
        step();
        chk_reset_state();
        #2 rst = 1'b0;
        n = 0;
        idle_chk(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
